// File: rtl/lfu_buf_ctrl_if.sv
// Request/grant/response bundle between two requesters and the LFU buffer controller.
interface lfu_buf_ctrl_if;
  logic       a_req;
  logic       a_alloc;
  logic [1:0] a_buf;
  logic       a_gnt;
  logic       b_req;
  logic       b_alloc;
  logic [1:0] b_buf;
  logic       b_gnt;
  logic       rsp_valid;
  logic       rsp_src;
  logic       rsp_alloc;
  logic [1:0] rsp_buf;
  logic       age_busy;

  modport master (
    output a_req, a_alloc, a_buf, b_req, b_alloc, b_buf,
    input  a_gnt, b_gnt, rsp_valid, rsp_src, rsp_alloc, rsp_buf, age_busy
  );

  modport slave (
    input  a_req, a_alloc, a_buf, b_req, b_alloc, b_buf,
    output a_gnt, b_gnt, rsp_valid, rsp_src, rsp_alloc, rsp_buf, age_busy
  );
endinterface

// File: rtl/lfu_buf_ctrl.sv
// Two-requester controller for a 4-entry buffer pool with LFU victim selection
// and periodic halving of the per-buffer use counts.
//
// state | meaning
// RUN   | grants allowed, one operation accepted per cycle at most
// AGE   | single cycle: no grants, all counts halved, op counter cleared
module lfu_buf_ctrl #(
  parameter int CNT_W      = 4,
  parameter int AGE_PERIOD = 16
) (
  input logic           clk,
  input logic           rst_n,
  lfu_buf_ctrl_if.slave bus
);

  typedef enum logic {S_RUN = 1'b0, S_AGE = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [7:0]       LAST_OP = 8'(AGE_PERIOD - 1);

  state_t           state_q, state_d;
  logic [7:0]       op_cnt_q, op_cnt_d;
  logic             rr_last_q, rr_last_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_src_q, rsp_src_d;
  logic             rsp_alloc_q, rsp_alloc_d;
  logic [1:0]       rsp_buf_q, rsp_buf_d;

  logic             gnt_a, gnt_b, granted, op_alloc;
  logic [1:0]       op_buf, victim;
  logic [CNT_W-1:0] min_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      op_cnt_q    <= '0;
      rr_last_q   <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_src_q   <= 1'b0;
      rsp_alloc_q <= 1'b0;
      rsp_buf_q   <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      op_cnt_q    <= op_cnt_d;
      rr_last_q   <= rr_last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_src_q   <= rsp_src_d;
      rsp_alloc_q <= rsp_alloc_d;
      rsp_buf_q   <= rsp_buf_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (granted && op_cnt_q == LAST_OP) state_d = S_AGE;
      S_AGE:   state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // rr_last_q = 1 means B won the last contended cycle, so A goes next.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (state_q == S_RUN) begin
      if (bus.a_req && bus.b_req) begin
        gnt_a = rr_last_q;
        gnt_b = !rr_last_q;
      end else begin
        gnt_a = bus.a_req;
        gnt_b = bus.b_req;
      end
    end
  end

  assign granted       = gnt_a | gnt_b;
  assign op_alloc      = gnt_b ? bus.b_alloc : bus.a_alloc;
  assign op_buf        = gnt_b ? bus.b_buf : bus.a_buf;
  assign bus.a_gnt     = gnt_a;
  assign bus.b_gnt     = gnt_b;
  assign bus.age_busy  = (state_q == S_AGE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_src   = rsp_src_q;
  assign bus.rsp_alloc = rsp_alloc_q;
  assign bus.rsp_buf   = rsp_buf_q;

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    victim  = 2'd0;
    min_cnt = cnt_q[0];
    for (int i = 1; i < 4; i++) begin
      if (cnt_q[i] < min_cnt) begin
        min_cnt = cnt_q[i];
        victim  = 2'(i);
      end
    end
  end

  always_comb begin
    op_cnt_d    = op_cnt_q;
    rr_last_d   = rr_last_q;
    rsp_valid_d = granted;
    rsp_src_d   = rsp_src_q;
    rsp_alloc_d = rsp_alloc_q;
    rsp_buf_d   = rsp_buf_q;
    for (int i = 0; i < 4; i++) cnt_d[i] = cnt_q[i];

    if (state_q == S_AGE) begin
      op_cnt_d = '0;
      for (int i = 0; i < 4; i++) cnt_d[i] = cnt_q[i] >> 1;
    end else if (granted) begin
      op_cnt_d    = op_cnt_q + 8'd1;
      rsp_src_d   = gnt_b;
      rsp_alloc_d = op_alloc;
      if (bus.a_req && bus.b_req) rr_last_d = gnt_b;
      if (op_alloc) begin
        cnt_d[victim] = CNT_ONE;
        rsp_buf_d     = victim;
      end else begin
        if (cnt_q[op_buf] != CNT_MAX) cnt_d[op_buf] = cnt_q[op_buf] + CNT_ONE;
        rsp_buf_d = op_buf;
      end
    end
  end

endmodule

// File: tb/tb_lfu_buf_ctrl.sv
// Randomized and directed bench for lfu_buf_ctrl against a behavioural pool model.
module tb_lfu_buf_ctrl;
  localparam int CNT_W      = 4;
  localparam int AGE_PERIOD = 16;
  localparam int CNT_SAT    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lfu_buf_ctrl_if bus ();

  lfu_buf_ctrl #(.CNT_W(CNT_W), .AGE_PERIOD(AGE_PERIOD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_bad = 0;

  // model state
  int m_cnt [4];
  int m_ops;
  bit m_age;
  bit m_last_b;
  bit e_rv, e_src, e_alloc;
  int e_buf;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lfu_pick();
    int best = 0;
    for (int i = 1; i < 4; i++) if (m_cnt[i] < m_cnt[best]) best = i;
    return best;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_ops = 0; m_age = 0; m_last_b = 1;
    e_rv = 0; e_src = 0; e_alloc = 0; e_buf = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit ar, input bit aa, input bit [1:0] ab,
                      input bit br, input bit ba, input bit [1:0] bb,
                      output bit ga, output bit gb);
    bit eg_a, eg_b, op_alloc;
    int op_buf;
    bus.a_req = ar; bus.a_alloc = aa; bus.a_buf = ab;
    bus.b_req = br; bus.b_alloc = ba; bus.b_buf = bb;
    @(negedge clk);
    eg_a = 0; eg_b = 0;
    if (!m_age) begin
      if (ar && br) begin
        eg_a = m_last_b;
        eg_b = !m_last_b;
        m_last_b = eg_b;
      end else begin
        eg_a = ar;
        eg_b = br;
      end
    end
    chk("a_gnt", int'(bus.a_gnt), int'(eg_a));
    chk("b_gnt", int'(bus.b_gnt), int'(eg_b));
    chk("age_busy", int'(bus.age_busy), int'(m_age));
    chk("rsp_valid", int'(bus.rsp_valid), int'(e_rv));
    chk("rsp_src", int'(bus.rsp_src), int'(e_src));
    chk("rsp_alloc", int'(bus.rsp_alloc), int'(e_alloc));
    chk("rsp_buf", int'(bus.rsp_buf), e_buf);

    e_rv = eg_a | eg_b;
    if (m_age) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = m_cnt[i] / 2;
      m_ops = 0;
      m_age = 0;
    end else if (e_rv) begin
      op_alloc = eg_b ? ba : aa;
      op_buf   = eg_b ? int'(bb) : int'(ab);
      if (op_alloc) begin
        e_buf = lfu_pick();
        m_cnt[e_buf] = 1;
      end else begin
        if (m_cnt[op_buf] < CNT_SAT) m_cnt[op_buf]++;
        e_buf = op_buf;
      end
      e_src = eg_b;
      e_alloc = op_alloc;
      m_ops++;
      if (m_ops == AGE_PERIOD) m_age = 1;
    end
    ga = eg_a; gb = eg_b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit ga, gb;
    bit a_pend, a_al, b_pend, b_al;
    bit [1:0] a_bf, b_bf;
    bus.a_req = 0; bus.a_alloc = 0; bus.a_buf = 0;
    bus.b_req = 0; bus.b_alloc = 0; bus.b_buf = 0;
    model_reset();
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // reset state, then two A allocations
    step(0, 0, 0, 0, 0, 0, ga, gb);
    step(1, 1, 0, 0, 0, 0, ga, gb);
    step(1, 1, 0, 0, 0, 0, ga, gb);
    step(0, 0, 0, 0, 0, 0, ga, gb);

    // contended refs to buffer 3 alternate starting with A
    for (int i = 0; i < 8; i++) step(1, 0, 3, 1, 0, 3, ga, gb);
    step(0, 0, 0, 0, 0, 0, ga, gb);

    // saturation plus aging pass with A held during the AGE cycle
    do_reset();
    for (int i = 0; i < 18; i++) step(1, 0, 0, 0, 0, 0, ga, gb);
    step(1, 1, 0, 0, 0, 0, ga, gb);
    step(0, 0, 0, 0, 0, 0, ga, gb);

    // preload {2,1,1,3}, then two allocations
    do_reset();
    step(1, 0, 0, 0, 0, 0, ga, gb);
    step(1, 0, 0, 0, 0, 0, ga, gb);
    step(1, 0, 1, 0, 0, 0, ga, gb);
    step(0, 0, 0, 1, 0, 2, ga, gb);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 3, ga, gb);
    step(1, 1, 0, 0, 0, 0, ga, gb);
    step(0, 0, 0, 1, 1, 0, ga, gb);
    step(0, 0, 0, 0, 0, 0, ga, gb);

    // randomized traffic; each side holds its op until granted
    a_pend = 0; b_pend = 0; a_al = 0; b_al = 0; a_bf = 0; b_bf = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!a_pend && $urandom_range(0, 3) != 0) begin
        a_pend = 1; a_al = ($urandom_range(0, 3) == 0); a_bf = 2'($urandom_range(0, 3));
      end
      if (!b_pend && $urandom_range(0, 3) != 0) begin
        b_pend = 1; b_al = ($urandom_range(0, 3) == 0); b_bf = 2'($urandom_range(0, 3));
      end
      step(a_pend, a_al, a_bf, b_pend, b_al, b_bf, ga, gb);
      if (ga) a_pend = 0;
      if (gb) b_pend = 0;
    end
    step(0, 0, 0, 0, 0, 0, ga, gb);
    step(0, 0, 0, 0, 0, 0, ga, gb);

    // asynchronous reset while a response is on the bus
    for (int i = 0; i < 3; i++) step(1, 0, 2'(i), 0, 0, 0, ga, gb);
    step(1, 1, 0, 0, 0, 0, ga, gb);
    bus.a_req = 0;
    chk("rsp_valid_pre_rst", int'(bus.rsp_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rsp_valid_in_rst", int'(bus.rsp_valid), 0);
    chk("rsp_buf_in_rst", int'(bus.rsp_buf), 0);
    model_reset();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 0, ga, gb);
    step(0, 0, 0, 0, 0, 0, ga, gb);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
